// File: rtl/dds_pkg.sv
// Shared types for the DDS phase generator: FSM state encoding and the config bundle.
package dds_pkg;

   localparam int DDS_PHASE_DW     = 16;
   localparam int DDS_ACC_DW       = 32;
   localparam int DDS_SWEEP_CNT_DW = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      TONE  = 2'd1,
      SWEEP = 2'd2
   } dds_pg_state_t;

   typedef struct packed {
      logic [DDS_ACC_DW-1:0]       ftw;
      logic [DDS_ACC_DW-1:0]       step;
      logic [DDS_SWEEP_CNT_DW-1:0] len;
      logic [DDS_PHASE_DW-1:0]     offset;
      logic                        rpt;
      logic                        sync;
   } dds_pg_cfg_t;

endpackage

// File: rtl/dds_phase_gen.sv
// Phase-accumulator NCO with fixed-tone and linear-chirp modes; phase words leave 2 edges after run rises.
// No output backpressure (downstream always accepts); config is held off only while a sweep is running.
module dds_phase_gen
   import dds_pkg::*;
#(
   parameter int PHASE_DW     = DDS_PHASE_DW,
   parameter int ACC_DW       = DDS_ACC_DW,
   parameter int SWEEP_CNT_DW = DDS_SWEEP_CNT_DW
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    cfg_valid,
   output logic                    cfg_ready,
   input  logic [ACC_DW-1:0]       cfg_ftw,
   input  logic [ACC_DW-1:0]       cfg_step,
   input  logic [SWEEP_CNT_DW-1:0] cfg_len,
   input  logic [PHASE_DW-1:0]     cfg_offset,
   input  logic                    cfg_repeat,
   input  logic                    cfg_sync,
   input  logic                    run,
   input  logic                    sync,
   output logic [PHASE_DW-1:0]     m_axis_phase_tdata,
   output logic                    m_axis_phase_tvalid,
   output logic                    busy,
   output logic                    sweep_done
);

   localparam logic [SWEEP_CNT_DW-1:0] CNT_ONE = SWEEP_CNT_DW'(1);

   dds_pg_state_t           state_q, state_d;
   logic [ACC_DW-1:0]       acc_q, acc_d;
   logic [ACC_DW-1:0]       ftw_cur_q, ftw_cur_d;
   logic [ACC_DW-1:0]       ftw_start_q, ftw_start_d;
   logic [ACC_DW-1:0]       step_q, step_d;
   logic [SWEEP_CNT_DW-1:0] count_q, count_d;
   logic [SWEEP_CNT_DW-1:0] len_q, len_d;
   logic [PHASE_DW-1:0]     offset_q, offset_d;
   logic                    repeat_q, repeat_d;
   logic [PHASE_DW-1:0]     tdata_q, tdata_d;
   logic                    tvalid_q, tvalid_d;
   logic                    done_q, done_d;
   logic                    active;
   logic                    cfg_accept;

   assign active     = (state_q != IDLE);
   assign cfg_ready  = (state_q != SWEEP);
   assign cfg_accept = cfg_valid & cfg_ready;

   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      ftw_cur_d   = ftw_cur_q;
      ftw_start_d = ftw_start_q;
      step_d      = step_q;
      count_d     = count_q;
      len_d       = len_q;
      offset_d    = offset_q;
      repeat_d    = repeat_q;
      tdata_d     = tdata_q;
      tvalid_d    = active;
      done_d      = 1'b0;

      // The emitted sample always carries the pre-add accumulator.
      if (active) begin
         tdata_d = acc_q[ACC_DW-1 -: PHASE_DW] + offset_q;
         acc_d   = acc_q + ftw_cur_q;
      end

      if (state_q == SWEEP) begin
         ftw_cur_d = ftw_cur_q + step_q;
         count_d   = count_q - CNT_ONE;
         if (count_q == CNT_ONE) begin
            done_d = 1'b1;
            if (repeat_q) begin
               ftw_cur_d = ftw_start_q;
               count_d   = len_q;
            end else begin
               state_d = TONE;
            end
         end
      end

      if (cfg_accept) begin
         ftw_cur_d   = cfg_ftw;
         ftw_start_d = cfg_ftw;
         step_d      = cfg_step;
         count_d     = cfg_len;
         len_d       = cfg_len;
         offset_d    = cfg_offset;
         repeat_d    = cfg_repeat;
         if (cfg_sync) begin
            acc_d = '0;
         end
         if (state_q == TONE) begin
            state_d = (cfg_len != '0) ? SWEEP : TONE;
         end
      end

      if (sync) begin
         acc_d = '0;
      end

      // Pausing holds acc/ftw/count, so resume picks up the interrupted sweep or tone.
      if (state_q == IDLE) begin
         if (run) begin
            state_d = (count_d != '0) ? SWEEP : TONE;
         end
      end else if (!run) begin
         state_d = IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         acc_q       <= '0;
         ftw_cur_q   <= '0;
         ftw_start_q <= '0;
         step_q      <= '0;
         count_q     <= '0;
         len_q       <= '0;
         offset_q    <= '0;
         repeat_q    <= 1'b0;
         tdata_q     <= '0;
         tvalid_q    <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         ftw_cur_q   <= ftw_cur_d;
         ftw_start_q <= ftw_start_d;
         step_q      <= step_d;
         count_q     <= count_d;
         len_q       <= len_d;
         offset_q    <= offset_d;
         repeat_q    <= repeat_d;
         tdata_q     <= tdata_d;
         tvalid_q    <= tvalid_d;
         done_q      <= done_d;
      end
   end

   assign m_axis_phase_tdata  = tdata_q;
   assign m_axis_phase_tvalid = tvalid_q;
   assign busy                = active;
   assign sweep_done          = done_q;

endmodule
